irq_arbiter: RTL

Interrupt arbiter for the single-cycle CPU's peripheral bus. Collects up to `NSRC` peripheral interrupt sources and prioritises them. Drives the CPU's single `IRQ` line, tracking one in-service interrupt at a time. Sits in the peripheral address space (address bit 30 set), beside the other peripherals feeding `PerData`.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt arbiter: FSM state encoding, register
// offsets, default base address and id width.
package irq_pkg;

  localparam int unsigned IdW = 4;

  localparam logic [31:0] DefaultBase = 32'h4000_0030;

  localparam logic [31:0] OffPend   = 32'h0000_0000;
  localparam logic [31:0] OffMask   = 32'h0000_0004;
  localparam logic [31:0] OffActive = 32'h0000_0008;
  localparam logic [31:0] OffAck    = 32'h0000_000C;
  localparam logic [31:0] OffLatMax = 32'h0000_0010;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StReq     = 2'd1;
  localparam state_t StService = 2'd2;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins, reports any/id.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0] vec,
  output logic            any,
  output logic [IdW-1:0]  id
);

  // Scan high to low so the lowest set index is written last.
  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any = 1'b1;
        id  = IdW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Peripheral-bus interrupt arbiter driving the CPU IRQ line, one in-service
// interrupt at a time. Define IRQ_LATENCY_EN to add the max-latency register.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter logic [31:0] BASE = DefaultBase
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            pc_31,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            wr,
  input  logic            rd,
  output logic [31:0]     rdata,
  output logic            irq
);

  localparam logic [31:0] AddrPend   = BASE + OffPend;
  localparam logic [31:0] AddrMask   = BASE + OffMask;
  localparam logic [31:0] AddrActive = BASE + OffActive;
  localparam logic [31:0] AddrAck    = BASE + OffAck;

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] elig;

  logic            any;
  logic [IdW-1:0]  win_id;
  logic [IdW-1:0]  active_id_q;
  logic            active_valid_q;

  state_t          state_q, state_d;

  logic            sel_pend, sel_mask, sel_active, sel_ack;
  logic            wr_pend, wr_mask, ack_hit;

  assign sel_pend   = (addr == AddrPend);
  assign sel_mask   = (addr == AddrMask);
  assign sel_active = (addr == AddrActive);
  assign sel_ack    = (addr == AddrAck);

  assign wr_pend = wr & sel_pend;
  assign wr_mask = wr & sel_mask;
  assign ack_hit = wr & sel_ack & (state_q == StService) & (wdata[IdW-1:0] == active_id_q);

  assign rise = src_irq & ~src_q;
  assign elig = pend_q & mask_q;

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio (
    .vec (elig),
    .any (any),
    .id  (win_id)
  );

  always_comb begin
    pend_clr = '0;
    if (wr_pend) begin
      pend_clr = wdata[NSRC-1:0];
    end
    for (int i = 0; i < int'(NSRC); i++) begin
      if (ack_hit && (active_id_q == IdW'(i))) begin
        pend_clr[i] = 1'b1;
      end
    end
  end

  // A new edge overrides a clear of the same bit in the same cycle.
  assign pend_d = (pend_q & ~pend_clr) | rise;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (any && !pc_31) state_d = StReq;
      end
      StReq: begin
        if (!any)       state_d = StIdle;
        else if (pc_31) state_d = StService;
      end
      StService: begin
        if (ack_hit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q          <= '0;
      pend_q         <= '0;
      mask_q         <= '0;
      state_q        <= StIdle;
      active_id_q    <= '0;
      active_valid_q <= 1'b0;
    end else begin
      src_q   <= src_irq;
      pend_q  <= pend_d;
      state_q <= state_d;
      if (wr_mask) begin
        mask_q <= wdata[NSRC-1:0];
      end
      if (state_q == StReq && state_d == StService) begin
        active_id_q    <= win_id;
        active_valid_q <= 1'b1;
      end else if (ack_hit) begin
        active_valid_q <= 1'b0;
      end
    end
  end

  assign irq = (state_q == StReq);

`ifdef IRQ_LATENCY_EN
  localparam logic [31:0] AddrLatMax = BASE + OffLatMax;

  logic        sel_lat;
  logic [15:0] lat_cnt_q;
  logic [15:0] lat_max_q;

  assign sel_lat = (addr == AddrLatMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt_q <= '0;
      lat_max_q <= '0;
    end else begin
      if (state_q == StIdle && state_d == StReq) begin
        lat_cnt_q <= '0;
      end else if (state_q != StIdle && lat_cnt_q != 16'hFFFF) begin
        lat_cnt_q <= lat_cnt_q + 16'd1;
      end
      if (wr && sel_lat) begin
        lat_max_q <= '0;
      end else if (ack_hit && lat_cnt_q > lat_max_q) begin
        lat_max_q <= lat_cnt_q;
      end
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_pend) begin
        rdata[NSRC-1:0] = pend_q;
      end else if (sel_mask) begin
        rdata[NSRC-1:0] = mask_q;
      end else if (sel_active) begin
        rdata = {active_valid_q, {(31 - IdW){1'b0}}, active_id_q};
      end
`ifdef IRQ_LATENCY_EN
      if (sel_lat) begin
        rdata[15:0] = lat_max_q;
      end
`endif
    end
  end

  // Upper store-data bits have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule
